// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings and timing constants.
// Used by uart_rx_dfs and uart_tx_dfs so both sides agree on bit timing.
package uart_pkg;

   localparam int CNT_W                = 13;
   localparam int DEFAULT_CLKS_PER_BIT = 5208;

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] START     = 3'd1;
   localparam logic [2:0] DATA      = 3'd2;
   localparam logic [2:0] STOP      = 3'd3;
   localparam logic [2:0] CLEANUP   = 3'd4;
   localparam logic [2:0] WAIT_HIGH = 3'd5;

   // Mid-bit offset in clocks for a given bit period.
   function automatic int half_bit(input int clks_per_bit);
      return (clks_per_bit - 1) / 2;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; reset value is selectable
// so idle-high lines (e.g. UART RX) do not look like a falling edge out of reset.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_dfs.sv
// 8N1 UART receiver, LSB first: start bit qualified at mid-bit, data and stop sampled
// at mid-bit; reports good bytes, framing errors and break (all-zero frame, stop low).
module uart_rx_dfs
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_RX_Serial,
   output logic       o_RX_DV,
   output logic [7:0] o_RX_Byte,
   output logic       o_RX_Active,
   output logic       o_Frame_Err,
   output logic       o_Break
);

   localparam int              HALF_BIT = half_bit(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_BIT);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   logic             rx_sync;

   logic [2:0]       state_q,  state_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [2:0]       idx_q,    idx_d;
   logic [7:0]       shift_q,  shift_d;
   logic [7:0]       byte_q,   byte_d;
   logic             dv_q,     dv_d;
   logic             ferr_q,   ferr_d;
   logic             brk_q,    brk_d;
   logic             active_q, active_d;

   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk_i (i_Clock),
      .rst_i (i_Reset),
      .d_i   (i_RX_Serial),
      .q_o   (rx_sync)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + CNT_W'(1);
      idx_d    = idx_q;
      shift_d  = shift_q;
      byte_d   = byte_q;
      dv_d     = 1'b0;
      ferr_d   = 1'b0;
      brk_d    = brk_q;
      active_d = active_q;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (!rx_sync) begin
               state_d  = START;
               active_d = 1'b1;
            end
         end

         // A line that is high again at mid start bit was only a glitch.
         START: begin
            if (cnt_q == HALF_CNT) begin
               cnt_d = '0;
               if (!rx_sync) begin
                  state_d = DATA;
               end else begin
                  state_d  = IDLE;
                  active_d = 1'b0;
               end
            end
         end

         DATA: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_sync;
               if (idx_q == 3'd7) begin
                  idx_d   = '0;
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end

         STOP: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d = '0;
               if (rx_sync) begin
                  byte_d   = shift_q;
                  dv_d     = 1'b1;
                  active_d = 1'b0;
                  state_d  = CLEANUP;
               end else begin
                  // Stop low: keep the last good byte; all-zero frame means break.
                  ferr_d  = 1'b1;
                  brk_d   = (shift_q == 8'h00);
                  state_d = WAIT_HIGH;
               end
            end
         end

         CLEANUP: begin
            cnt_d   = '0;
            state_d = IDLE;
         end

         WAIT_HIGH: begin
            cnt_d = '0;
            if (rx_sync) begin
               brk_d    = 1'b0;
               active_d = 1'b0;
               state_d  = IDLE;
            end
         end

         default: begin
            cnt_d    = '0;
            idx_d    = '0;
            brk_d    = 1'b0;
            active_d = 1'b0;
            state_d  = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         byte_q   <= '0;
         dv_q     <= 1'b0;
         ferr_q   <= 1'b0;
         brk_q    <= 1'b0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         byte_q   <= byte_d;
         dv_q     <= dv_d;
         ferr_q   <= ferr_d;
         brk_q    <= brk_d;
         active_q <= active_d;
      end
   end

   assign o_RX_DV     = dv_q;
   assign o_RX_Byte   = byte_q;
   assign o_RX_Active = active_q;
   assign o_Frame_Err = ferr_q;
   assign o_Break     = brk_q;

endmodule

// File: tb/tb_uart_rx_dfs.sv
// Directed + randomised bench for uart_rx_dfs at 16 clocks per bit; received bytes
// are matched against an expected-byte queue built from the frames the bench sends.
module tb_uart_rx_dfs;

   localparam int CPB  = 16;
   localparam int HALF = (CPB - 1) / 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic       dv;
   logic [7:0] rx_byte;
   logic       active;
   logic       ferr;
   logic       brk;

   int n_assert = 0;
   int n_fail   = 0;
   int dv_cnt   = 0;
   int fe_cnt   = 0;

   logic [7:0] exp_q[$];
   logic [7:0] last_good;

   uart_rx_dfs #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .i_Clock     (clk),
      .i_Reset     (rst),
      .i_RX_Serial (rx),
      .o_RX_DV     (dv),
      .o_RX_Byte   (rx_byte),
      .o_RX_Active (active),
      .o_Frame_Err (ferr),
      .o_Break     (brk)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every DV pulse must match the oldest outstanding expected byte.
   always @(negedge clk) begin
      if (!rst) begin
         if (dv || ferr) chk("dv_fe_exclusive", {31'b0, dv & ferr}, 32'h0);
         if (dv) begin
            dv_cnt++;
            chk("dv_expected", {31'b0, exp_q.size() > 0}, 32'h1);
            if (exp_q.size() > 0) chk("dv_byte", {24'b0, rx_byte}, {24'b0, exp_q.pop_front()});
         end
         if (ferr) fe_cnt++;
      end
   end

   // Drives one 10-bit frame starting at the current negedge; checks Active mid-bit.
   task automatic send_frame(input logic [7:0] b, input logic stop_v);
      logic [9:0] f;
      f = {stop_v, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = f[i];
         for (int c = 0; c < CPB; c++) begin
            @(negedge clk);
            if (c == 8 && i < 9) chk("active_in_frame", {31'b0, active}, 32'h1);
         end
      end
   endtask

   task automatic send_good(input logic [7:0] b);
      exp_q.push_back(b);
      send_frame(b, 1'b1);
      last_good = b;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int base_dv;
      int base_fe;
      int rise_idx;
      int fall_idx;
      logic [7:0] rb;

      // Reset state
      rx  = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_dv",     {31'b0, dv},     32'h0);
      chk("rst_byte",   {24'b0, rx_byte}, 32'h0);
      chk("rst_active", {31'b0, active}, 32'h0);
      chk("rst_ferr",   {31'b0, ferr},   32'h0);
      chk("rst_break",  {31'b0, brk},    32'h0);
      rst = 1'b0;
      last_good = 8'h00;
      idle(20);
      chk("idle_active", {31'b0, active}, 32'h0);

      // Single frame 0xA5
      send_good(8'hA5);
      idle(10);
      chk("a5_dv_cnt", dv_cnt, 32'd1);
      chk("a5_byte",   {24'b0, rx_byte}, 32'hA5);
      chk("a5_no_fe",  fe_cnt, 32'd0);
      chk("a5_active_done", {31'b0, active}, 32'h0);

      // Back-to-back frames, no idle gap
      send_good(8'h00);
      send_good(8'hFF);
      send_good(8'h3C);
      idle(10);
      chk("b2b_dv_cnt", dv_cnt, 32'd4);
      chk("b2b_byte",   {24'b0, rx_byte}, 32'h3C);

      // 5-cycle low glitch
      base_dv  = dv_cnt;
      base_fe  = fe_cnt;
      rise_idx = -1;
      fall_idx = -1;
      rx = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (c == 4) rx = 1'b1;
         if (active && rise_idx < 0) rise_idx = c;
         if (!active && rise_idx >= 0 && fall_idx < 0) fall_idx = c;
      end
      chk("glitch_active_rose", {31'b0, rise_idx >= 0}, 32'h1);
      chk("glitch_active_fell", {31'b0, fall_idx >= 0}, 32'h1);
      chk("glitch_drop_time",   {31'b0, (fall_idx - rise_idx) <= HALF + 3}, 32'h1);
      chk("glitch_no_dv", dv_cnt, base_dv);
      chk("glitch_no_fe", fe_cnt, base_fe);
      send_good(8'h55);
      idle(10);
      chk("after_glitch_byte", {24'b0, rx_byte}, 32'h55);

      // Framing error with non-zero data
      base_dv = dv_cnt;
      base_fe = fe_cnt;
      send_frame(8'h81, 1'b0);
      chk("fe_pulse",     fe_cnt, base_fe + 1);
      chk("fe_byte_held", {24'b0, rx_byte}, {24'b0, last_good});
      chk("fe_no_break",  {31'b0, brk}, 32'h0);
      chk("fe_no_dv",     dv_cnt, base_dv);
      idle(10);
      send_good(8'h42);
      idle(10);
      chk("after_fe_byte", {24'b0, rx_byte}, 32'h42);
      chk("after_fe_dv",   dv_cnt, base_dv + 1);

      // Break: line low for 30 bit periods
      base_dv = dv_cnt;
      base_fe = fe_cnt;
      rx = 1'b0;
      repeat (30 * CPB) @(negedge clk);
      chk("break_high",  {31'b0, brk}, 32'h1);
      chk("break_fe",    fe_cnt, base_fe + 1);
      chk("break_no_dv", dv_cnt, base_dv);
      idle(6);
      chk("break_cleared", {31'b0, brk}, 32'h0);
      chk("break_byte_held", {24'b0, rx_byte}, {24'b0, last_good});
      idle(10);

      // Reset in the middle of 0xF0 (during data bit 4)
      base_dv = dv_cnt;
      base_fe = fe_cnt;
      rx = 1'b0;
      repeat (5 * CPB) @(negedge clk);
      rx = 1'b1;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_dv",     {31'b0, dv},     32'h0);
      chk("midrst_byte",   {24'b0, rx_byte}, 32'h0);
      chk("midrst_active", {31'b0, active}, 32'h0);
      chk("midrst_ferr",   {31'b0, ferr},   32'h0);
      chk("midrst_break",  {31'b0, brk},    32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      last_good = 8'h00;
      idle(4 * CPB);
      chk("aborted_no_dv", dv_cnt, base_dv);
      chk("aborted_no_fe", fe_cnt, base_fe);
      chk("aborted_idle",  {31'b0, active}, 32'h0);
      send_good(8'h0F);
      idle(10);
      chk("after_rst_byte", {24'b0, rx_byte}, 32'h0F);

      // Random bytes with random idle gaps (including zero gap)
      base_dv = dv_cnt;
      base_fe = fe_cnt;
      for (int n = 0; n < 10; n++) begin
         rb = 8'($urandom_range(0, 255));
         send_good(rb);
         idle($urandom_range(0, 20));
      end
      idle(20);
      chk("rand_dv_cnt", dv_cnt, base_dv + 10);
      chk("rand_no_fe",  fe_cnt, base_fe);
      chk("rand_last",   {24'b0, rx_byte}, {24'b0, last_good});
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_dfs.md
Name: uart_rx_dfs

Overview:
- 8N1 UART receiver, LSB first. It is the receive-side counterpart of the existing uart_tx_dfs transmitter and shares the same CLKS_PER_BIT timing convention.
- It synchronises the asynchronous serial line, qualifies the start bit at mid-bit, and samples each data bit and the stop bit at mid-bit.
- It presents each received byte with a one-cycle valid strobe, and reports framing errors and break conditions.
- It sits at the board-level serial input, feeding the command/data path.

Parameters:
- CLKS_PER_BIT, 5208: clock cycles per bit (Fclk/baud; 50 MHz / 9600). Legal range 4..8191.
- HALF_BIT (localparam), (CLKS_PER_BIT-1)/2: mid-bit offset.

Ports:
- i_Clock  input  1  system clock; all logic on its rising edge.
- i_Reset  input  1  asynchronous, active-high reset.
- i_RX_Serial  input  1  asynchronous serial line; idles high.
- o_RX_DV  output  1  one-cycle pulse: o_RX_Byte holds a valid byte.
- o_RX_Byte  output  8  last good byte received; held until the next good byte.
- o_RX_Active  output  1  high while a frame is being received.
- o_Frame_Err  output  1  one-cycle pulse: stop bit sampled low.
- o_Break  output  1  level; high while the line is held low after a framing error with byte==0x00.

Behaviour:
- Reset:
  - One clock (i_Clock); reset is asynchronous and active-high (i_Reset).
  - During reset: sync flops=1, state=IDLE, counter=0, bit index=0, shift register=0.
  - All outputs are 0 during reset.
- Synchroniser:
  - Two flops, i_RX_Serial -> meta -> sync. All decisions use sync only (2-cycle input latency).
- Counter:
  - 13-bit clock counter, 3-bit bit index.
  - The counter resets to 0 on every state change.
- States (3-bit encoding):
  - IDLE: sync==0 -> START. o_RX_Active rises on this transition.
  - START: count to HALF_BIT. At the count, sync==0 -> DATA; sync==1 -> IDLE (glitch rejected; no output pulse; Active drops).
  - DATA: count to CLKS_PER_BIT-1, then shift sync into bit[index] and increment index. After bit 7 -> STOP, index returns to 0.
  - STOP: count to CLKS_PER_BIT-1, then sample.
    - sync==1: o_RX_Byte <= shift reg, o_RX_DV=1 for exactly one cycle -> CLEANUP.
    - sync==0: o_Frame_Err=1 for one cycle, o_RX_Byte unchanged; if shift reg==0x00, o_Break=1 -> WAIT_HIGH.
  - CLEANUP: one cycle, o_RX_Active=0 -> IDLE.
  - WAIT_HIGH: stay until sync==1, then o_Break=0, o_RX_Active=0 -> IDLE. No new frame can start until the line has returned high.
  - Undefined encodings -> IDLE.
- Timing:
  - Samples are taken at HALF_BIT + k*CLKS_PER_BIT cycles after the synchronised falling edge.
  - o_RX_DV asserts HALF_BIT + 9*CLKS_PER_BIT + 1 cycles after sync first reads 0.
- Boundary conditions:
  - Back-to-back frames: a start edge arriving during CLEANUP is detected in the following IDLE cycle. Loss is at most 1 cycle, which is tolerated.
  - Line-low glitches shorter than HALF_BIT cycles never leave START.
  - Reset mid-frame: immediate return to IDLE; any partial byte is discarded; no pulse.
  - o_RX_DV and o_Frame_Err are never high in the same cycle.

Decomposition:
- Shared package uart_pkg:
  - state enum / localparams: IDLE, START, DATA, STOP, CLEANUP, WAIT_HIGH.
  - CNT_W=13.
  - DEFAULT_CLKS_PER_BIT=5208.
  - The same package is reused by uart_tx_dfs.
- One natural sub-module, sync_2ff: a 1-bit two-flop synchroniser with async reset, set-to-1 reset value via parameter. It is reused elsewhere for asynchronous inputs.

Test Plan:
- CLKS_PER_BIT=16; drive 0xA5 as 8N1 at 16 cycles/bit -> one o_RX_DV pulse, o_RX_Byte=0xA5, o_Frame_Err never high, o_RX_Active high for the whole frame.
- Back-to-back 0x00, 0xFF, 0x3C with no idle gap -> three DV pulses in order with matching bytes.
- Low glitch of 5 cycles on an idle line -> no DV, no Frame_Err; o_RX_Active drops within HALF_BIT+3 cycles; the next valid byte 0x55 is received correctly.
- Frame 0x81 with the stop bit forced low -> o_Frame_Err one-cycle pulse, o_RX_Byte keeps its previous value, o_Break=0; receiver waits for high, then receives 0x42.
- Line held low for 30 bit periods -> Frame_Err pulse, o_Break=1 until the line rises, then 0; no DV.
- Assert i_Reset at data bit 4 of 0xF0, release, send 0x0F -> no output during the aborted frame, all outputs 0 during reset, then DV with 0x0F.
